glb_rd_port_arbiter: RTL and testbench
======================================

// Module: glb_rd_port_arbiter
// PURPOSE
//  Shares the single GLB read port between the token-engine FIFO controllers
//  (ifmap, weight, ipsum, bias). Each controller raises a read request and a
//  GLB address. Each controller pushes its FIFO only in a cycle where its
//  permit is high; GLB read data is broadcast to all controllers.
//  Arbitration is round-robin with a bounded burst tenure, so no requester
//  starves and the port has no idle bubble between tenures.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2); index 0=ifmap,1=weight,2=ipsum,3=bias
//  ADDR_W     32  GLB byte-address width
//  MAX_BURST  8   max permitted beats per tenure (>=1)
// PORTS
//  clk            in   1               clock, rising edge
//  rst            in   1               asynchronous, active-high reset
//  arb_flush_i    in   1               sync flush: drop tenure, reset rr pointer
//  rd_req_i       in   NUM_REQ         per-requester read request (level)
//  rd_addr_i      in   NUM_REQ*ADDR_W  per-requester GLB address, slice k = req k
//  permit_o       out  NUM_REQ         one-hot; beat accepted for requester k
//  glb_rd_en_o    out  1               GLB read enable (= |permit_o)
//  glb_rd_addr_o  out  ADDR_W          address of permitted requester, else 0
//  owner_o        out  $clog2(NUM_REQ) current tenure owner
//  arb_busy_o     out  1               high while in BUSY
// BEHAVIOUR
//  Reset: state=IDLE, owner=0, burst_cnt=0, rr_ptr=0.
//  Reset outputs: permit_o=0, glb_rd_en_o=0, glb_rd_addr_o=0, owner_o=0, arb_busy_o=0.
//  State machine: IDLE, BUSY.
//  - IDLE: no permits.
//    - If |rd_req_i, the winner is the first asserted req scanning upward from rr_ptr (mod NUM_REQ).
//    - Next: owner<=winner, burst_cnt<=0, BUSY. First beat is the cycle after the request is seen.
//  - BUSY: permit_o[owner] = rd_req_i[owner] (combinational); glb_rd_addr_o = addr slice of owner.
//    - beat = permit_o[owner]; burst_cnt += 1 on each beat.
//  - Tenure ends when (a) rd_req_i[owner]=0, or (b) beat && burst_cnt==MAX_BURST-1.
//    - On end: rr_ptr<=owner+1 (wrap). Winner is searched from owner+1 over the current rd_req_i.
//    - In case (b) the owner is lowest priority, but it may win again if it is the only requester.
//    - If a winner exists: owner<=winner, burst_cnt<=0, stay BUSY. No bubble; the new owner's beat is next cycle.
//    - Else: go to IDLE.
//  Only one permit is ever high. A requester dropping req loses its tenure the same cycle, with no beat.
//  burst_cnt width is $clog2(MAX_BURST)+1 and never exceeds MAX_BURST-1.
//  owner+1 wraps modulo NUM_REQ, including when NUM_REQ is not a power of 2.
//  arb_flush_i (priority over all but rst):
//    - next state=IDLE, rr_ptr=0, burst_cnt=0, owner=0.
//    - permit_o is forced 0 in the flush cycle.
//  rst asserted mid-tenure: all outputs drop to reset values immediately (async); no beat is issued.
//  Request/address slices of non-owners are ignored. The owner's address may change every beat.
// TESTING
//  1. Only req2 high for 20 cycles, MAX_BURST=8.
//     -> permit_o=4'b0100 from cycle 1 for all 19 cycles.
//     -> owner_o=2, tenures re-grant with no gap.
//  2. req0 and req1 both held high.
//     -> permits alternate in blocks of 8: 0x1 x8, 0x2 x8, 0x1 x8.
//     -> glb_rd_en_o stays 1 throughout.
//  3. req3 granted; deassert req3 after 3 beats while req1 is high.
//     -> exactly 3 beats for requester 3, then permit_o=4'b0010 next cycle.
//  4. All four requesters high.
//     -> owner order 0,1,2,3,0; each tenure is 8 beats.
//     -> glb_rd_addr_o tracks the owner slice (e.g. 0x100,0x200,0x300,0x400).
//  5. arb_flush_i during req2's 4th beat.
//     -> permit_o=0 that cycle and the next.
//     -> regrant from rr_ptr=0 (req0 wins if high).
//  6. rst pulse mid-tenure.
//     -> all outputs 0 asynchronously.
//     -> after release with req1 high, first permit 4'b0010 one cycle later.

Source files
------------

// File: rtl/glb_rd_port_arbiter.sv
// glb_rd_port_arbiter: round-robin, burst-bounded arbiter sharing the single GLB read port
module glb_rd_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_flush_i,
  input  logic [NUM_REQ-1:0]          rd_req_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_REQ-1:0]          permit_o,
  output logic                        glb_rd_en_o,
  output logic [ADDR_W-1:0]           glb_rd_addr_o,
  output logic [$clog2(NUM_REQ)-1:0]  owner_o,
  output logic                        arb_busy_o
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]        state;
  logic [OW-1:0]     owner, rr_ptr, owner_inc, base, idx, win;
  logic [BW-1:0]     burst_cnt;
  logic              found, beat, tenure_end;
  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_a
    assign addr_a[g] = rd_addr_i[g*ADDR_W +: ADDR_W];
  end
  assign owner_inc     = (owner == OW'(NUM_REQ-1)) ? '0 : owner + 1'b1;
  assign beat          = (state == BUSY) && !arb_flush_i && rd_req_i[owner];
  assign tenure_end    = !rd_req_i[owner] || (beat && burst_cnt == BW'(MAX_BURST-1));
  assign permit_o      = beat ? (NUM_REQ'(1) << owner) : '0;
  assign glb_rd_en_o   = beat;
  assign glb_rd_addr_o = beat ? addr_a[owner] : '0;
  assign owner_o       = owner;
  assign arb_busy_o    = (state == BUSY);
  always_comb begin
    base  = (state == BUSY) ? owner_inc : rr_ptr;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = OW'((int'(base) + i) % NUM_REQ);
      if (rd_req_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else if (arb_flush_i) begin
      state     <= IDLE;
      owner     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        owner     <= win;
        burst_cnt <= '0;
        state     <= BUSY;
      end
    end else if (tenure_end) begin
      rr_ptr <= owner_inc;
      if (found) begin
        owner     <= win;
        burst_cnt <= '0;
      end else begin
        state <= IDLE;
      end
    end else begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_glb_rd_port_arbiter.sv
// tb_glb_rd_port_arbiter: directed self-checking bench for glb_rd_port_arbiter
module tb_glb_rd_port_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         arb_flush_i;
  logic [3:0]   rd_req_i;
  logic [127:0] rd_addr_i;
  logic [3:0]   permit_o;
  logic         glb_rd_en_o;
  logic [31:0]  glb_rd_addr_o;
  logic [1:0]   owner_o;
  logic         arb_busy_o;
  int n_cmp = 0;
  int n_bad = 0;
  int step  = 0;
  glb_rd_port_arbiter #(.NUM_REQ(4), .ADDR_W(32), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst), .arb_flush_i(arb_flush_i), .rd_req_i(rd_req_i),
    .rd_addr_i(rd_addr_i), .permit_o(permit_o), .glb_rd_en_o(glb_rd_en_o),
    .glb_rd_addr_o(glb_rd_addr_o), .owner_o(owner_o), .arb_busy_o(arb_busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".permit"}, 32'(permit_o), 32'h0);
    chk({tag, ".en"}, 32'(glb_rd_en_o), 32'h0);
    chk({tag, ".addr"}, glb_rd_addr_o, 32'h0);
    chk({tag, ".owner"}, 32'(owner_o), 32'h0);
    chk({tag, ".busy"}, 32'(arb_busy_o), 32'h0);
  endtask
  task automatic cyc(input string tag, input logic [3:0] req, input logic fl,
                     input logic [3:0] p, input int own, input logic busy);
    logic [31:0] a;
    @(negedge clk);
    a = 32'(32'h100 * (own + 1) + step);
    step++;
    rd_req_i = req;
    arb_flush_i = fl;
    rd_addr_i[own*32 +: 32] = a;
    #1;
    chk({tag, ".permit"}, 32'(permit_o), 32'(p));
    chk({tag, ".en"}, 32'(glb_rd_en_o), 32'(|p));
    chk({tag, ".addr"}, glb_rd_addr_o, (p != 4'b0) ? a : 32'h0);
    chk({tag, ".owner"}, 32'(owner_o), 32'(own));
    chk({tag, ".busy"}, 32'(arb_busy_o), 32'(busy));
  endtask
  initial begin
    rst = 1'b1;
    arb_flush_i = 1'b0;
    rd_req_i = 4'b0;
    rd_addr_i = '0;
    #3;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc("t1_idle", 4'b0100, 1'b0, 4'b0000, 0, 1'b0);
    repeat (19) cyc("t1_beat", 4'b0100, 1'b0, 4'b0100, 2, 1'b1);
    cyc("t1_drop", 4'b0000, 1'b0, 4'b0000, 2, 1'b1);
    cyc("t2_idle", 4'b0011, 1'b0, 4'b0000, 2, 1'b0);
    repeat (8) cyc("t2_r0a", 4'b0011, 1'b0, 4'b0001, 0, 1'b1);
    repeat (8) cyc("t2_r1", 4'b0011, 1'b0, 4'b0010, 1, 1'b1);
    repeat (8) cyc("t2_r0b", 4'b0011, 1'b0, 4'b0001, 0, 1'b1);
    cyc("t2_drop", 4'b0000, 1'b0, 4'b0000, 1, 1'b1);
    cyc("t3_idle", 4'b1010, 1'b0, 4'b0000, 1, 1'b0);
    repeat (3) cyc("t3_r3", 4'b1010, 1'b0, 4'b1000, 3, 1'b1);
    cyc("t3_drop3", 4'b0010, 1'b0, 4'b0000, 3, 1'b1);
    cyc("t3_r1", 4'b0010, 1'b0, 4'b0010, 1, 1'b1);
    cyc("t3_end", 4'b0000, 1'b0, 4'b0000, 1, 1'b1);
    cyc("t4_flush", 4'b0000, 1'b1, 4'b0000, 1, 1'b0);
    cyc("t4_idle", 4'b1111, 1'b0, 4'b0000, 0, 1'b0);
    for (int k = 0; k < 5; k++)
      repeat (8) cyc("t4_rr", 4'b1111, 1'b0, 4'(1 << (k % 4)), k % 4, 1'b1);
    cyc("t4_drop", 4'b0000, 1'b0, 4'b0000, 1, 1'b1);
    cyc("t5_idle", 4'b0101, 1'b0, 4'b0000, 1, 1'b0);
    repeat (3) cyc("t5_r2", 4'b0101, 1'b0, 4'b0100, 2, 1'b1);
    cyc("t5_flush", 4'b0101, 1'b1, 4'b0000, 2, 1'b1);
    cyc("t5_after", 4'b0101, 1'b0, 4'b0000, 0, 1'b0);
    repeat (2) cyc("t5_r0", 4'b0101, 1'b0, 4'b0001, 0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("t6_rst");
    rd_req_i = 4'b0010;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rel.permit", 32'(permit_o), 32'h0);
    cyc("t6_r1", 4'b0010, 1'b0, 4'b0010, 1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
